axi_lite_slave_regfile: RTL
===========================

Name: axi_lite_slave_regfile

Overview:
AXI4-Lite responder (subordinate) that terminates the transactions issued by the team's AXI-Lite master. It holds a bank of NUM_REGS 32-bit read/write registers with byte-strobe writes, and has independent write (AW/W/B) and read (AR/R) channels. Out-of-range accesses complete with SLVERR. Register contents are exported for control of downstream logic.

Parameters:
ADDR_W, 32, address width of AW/AR channels
NUM_REGS, 8, number of 32-bit registers (power of 2, >=2); register i at byte offset 4*i

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
awaddr_i  input  ADDR_W  write address
awvalid_i  input  1  write address valid
awready_o  output  1  write address ready
wdata_i  input  32  write data
wstrb_i  input  4  byte strobes; bit k enables wdata_i[8k+7:8k]
wvalid_i  input  1  write data valid
wready_o  output  1  write data ready
bresp_o  output  2  write response (00 OKAY, 10 SLVERR)
bvalid_o  output  1  write response valid
bready_i  input  1  write response ready
araddr_i  input  ADDR_W  read address
arvalid_i  input  1  read address valid
arready_o  output  1  read address ready
rdata_o  output  32  read data
rresp_o  output  2  read response (00 OKAY, 10 SLVERR)
rvalid_o  output  1  read data valid
rready_i  input  1  read data ready
regs_o  output  NUM_REGS*32  register contents; reg i at [32i+31:32i]
wr_pulse_o  output  1  one-cycle pulse when a valid register write commits
wr_idx_o  output  $clog2(NUM_REGS)  index of the committed write; valid while wr_pulse_o is high

Behaviour:
- Reset is decided: rst_n, asynchronous, active-low; clock clk.
- Reset values: all registers 0; bvalid_o, rvalid_o, wr_pulse_o 0; bresp_o, rresp_o 00; rdata_o 0; wr_idx_o 0; internal aw_held and w_held flags 0.
- Address decode: idx = addr[ADDR_W-1:2]; addr[1:0] ignored. The access is in range iff idx < NUM_REGS, with all higher bits compared (no aliasing).
- Write channel:
  - awready_o = !aw_held && !bvalid_o; wready_o = !w_held && !bvalid_o. Both are combinational and are 1 immediately after reset.
  - A valid&ready edge on AW latches awaddr and sets aw_held. A valid&ready edge on W latches wdata/wstrb and sets w_held. AW and W are accepted in either order, or in the same cycle.
  - Commit: on the first edge where aw_held && w_held:
    - In range: write the bytes enabled by the strobes, bresp_o<=00, wr_pulse_o<=1, wr_idx_o<=idx.
    - Out of range: no register change, bresp_o<=10, no pulse.
    - In both cases bvalid_o<=1 and aw_held/w_held are cleared.
  - Latency: one edge from the later of the AW/W handshakes to the commit and bvalid_o.
  - bvalid_o holds, with bresp_o stable, until bvalid_o&&bready_i. Only one write is outstanding; AW/W are blocked while bvalid_o is high.
  - wstrb=0000 with an in-range address: no data change, OKAY, wr_pulse_o still fires.
- Read channel:
  - arready_o = !rvalid_o.
  - On arvalid_i&&arready_o: rdata_o<=reg[idx] and rresp_o<=00 if in range; otherwise rdata_o<=0 and rresp_o<=10. rvalid_o<=1.
  - Read latency: 1 cycle.
  - rdata_o/rresp_o stay stable while rvalid_o&&!rready_i. rvalid_o clears on rvalid_o&&rready_i, so back-to-back reads take 2 cycles each.
- Simultaneous events:
  - Read and write channels operate fully in parallel.
  - If a read is accepted on the same edge as a write commit to the same register, the read returns the pre-write value.
  - A read accepted on any later edge sees the new value.
- wr_pulse_o is high for exactly one cycle per committed in-range write.
- regs_o reflects the register state directly (registered, no extra latency).
- Reset asserted mid-transaction: held AW/W and pending B/R are discarded, no response is issued, and registers return to 0.
- AXI WVALID/AWVALID stability is the master's responsibility. The block latches on the handshake edge, so later changes are ignored.

Test Plan:
- AW and W in the same cycle, addr 0x04, data 0xDEADBEEF, strb 1111 -> wr_pulse_o with wr_idx_o=1 one cycle later; bvalid_o=1 with bresp 00; regs_o[63:32]=0xDEADBEEF; read of 0x04 returns 0xDEADBEEF, rresp 00.
- W three cycles before AW (addr 0x08, data 0x11223344, strb 0101) on a register that already holds 0xFFFFFFFF -> reg2=0xFF22FF44; no commit before the AW handshake; bvalid_o 1 cycle after AW.
- Write to 0x20 (idx 8, out of range) -> bresp 10, no register change, no wr_pulse_o. Read of 0x1000 -> rdata_o 0, rresp 10.
- bready_i held low 5 cycles after a write -> bvalid_o and bresp_o stable; awready_o/wready_o stay 0; the next AW is accepted only after the B handshake.
- Read of reg 3 accepted on the same edge as a commit writing 0xA5A5A5A5 to reg 3 (old value 0x1) -> rdata_o=0x1; the next read returns 0xA5A5A5A5. rready_i held low 4 cycles -> rdata_o stable, arready_o 0.
- rst_n pulsed low after AW is accepted but before W -> bvalid_o stays 0, all regs 0; after reset a fresh write completes normally.

Source files
------------

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite subordinate register file: NUM_REGS x 32-bit registers, byte-strobe writes,
// independent write (AW/W/B) and read (AR/R) channels, SLVERR for out-of-range accesses.
module axi_lite_slave_regfile #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_W-1:0]             awaddr_i,
    input  logic                          awvalid_i,
    output logic                          awready_o,
    input  logic [31:0]                   wdata_i,
    input  logic [3:0]                    wstrb_i,
    input  logic                          wvalid_i,
    output logic                          wready_o,
    output logic [1:0]                    bresp_o,
    output logic                          bvalid_o,
    input  logic                          bready_i,
    input  logic [ADDR_W-1:0]             araddr_i,
    input  logic                          arvalid_i,
    output logic                          arready_o,
    output logic [31:0]                   rdata_o,
    output logic [1:0]                    rresp_o,
    output logic                          rvalid_o,
    input  logic                          rready_i,
    output logic [NUM_REGS*32-1:0]        regs_o,
    output logic                          wr_pulse_o,
    output logic [$clog2(NUM_REGS)-1:0]   wr_idx_o
);

    localparam int unsigned IDX_W  = $clog2(NUM_REGS);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic             aw_held_q, aw_held_d;
    logic             aw_ok_q, aw_ok_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic             w_held_q, w_held_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             wr_pulse_q, wr_pulse_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             rvalid_q, rvalid_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      regs_q [NUM_REGS];
    logic [31:0]      regs_d [NUM_REGS];

    logic             aw_hs, w_hs, ar_hs, commit;
    logic             aw_in_range, ar_in_range;
    logic [IDX_W-1:0] aw_idx_in, ar_idx_in;
    logic             unused_addr_bits;

    // Decode on the handshake; all bits above the index must be zero (no aliasing).
    assign aw_in_range = (awaddr_i[ADDR_W-1:IDX_W+2] == '0);
    assign ar_in_range = (araddr_i[ADDR_W-1:IDX_W+2] == '0);
    assign aw_idx_in   = awaddr_i[IDX_W+1:2];
    assign ar_idx_in   = araddr_i[IDX_W+1:2];
    assign unused_addr_bits = ^{awaddr_i[1:0], araddr_i[1:0]};

    assign awready_o = !aw_held_q && !bvalid_q;
    assign wready_o  = !w_held_q && !bvalid_q;
    assign arready_o = !rvalid_q;

    assign aw_hs  = awvalid_i && awready_o;
    assign w_hs   = wvalid_i && wready_o;
    assign ar_hs  = arvalid_i && arready_o;
    assign commit = aw_held_q && w_held_q;

    always_comb begin
        aw_held_d  = aw_held_q;
        aw_ok_d    = aw_ok_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx_q;
        regs_d     = regs_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_ok_d   = aw_in_range;
            aw_idx_d  = aw_idx_in;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = wdata_i;
            wstrb_d  = wstrb_i;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (aw_ok_q) begin
                for (int k = 0; k < 4; k++) begin
                    if (wstrb_q[k]) begin
                        regs_d[aw_idx_q][8*k +: 8] = wdata_q[8*k +: 8];
                    end
                end
                bresp_d    = OKAY;
                wr_pulse_d = 1'b1;
                wr_idx_d   = aw_idx_q;
            end else begin
                bresp_d = SLVERR;
            end
        end else if (bvalid_q && bready_i) begin
            bvalid_d = 1'b0;
        end
    end

    // Reads sample regs_q, so a read coinciding with a commit returns the old value.
    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (ar_in_range) begin
                rdata_d = regs_q[ar_idx_in];
                rresp_d = OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = SLVERR;
            end
        end else if (rvalid_q && rready_i) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_q  <= 1'b0;
            aw_ok_q    <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
            rvalid_q   <= 1'b0;
            rresp_q    <= OKAY;
            rdata_q    <= '0;
            regs_q     <= '{default: '0};
        end else begin
            aw_held_q  <= aw_held_d;
            aw_ok_q    <= aw_ok_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[32*i +: 32] = regs_q[i];
        end
    end

    assign bvalid_o   = bvalid_q;
    assign bresp_o    = bresp_q;
    assign wr_pulse_o = wr_pulse_q;
    assign wr_idx_o   = wr_idx_q;
    assign rvalid_o   = rvalid_q;
    assign rresp_o    = rresp_q;
    assign rdata_o    = rdata_q;

endmodule
